// File: rtl/rsa_modexp_decoder.sv
// rsa_modexp_decoder: m = c^d mod N via MSB-first square-and-multiply over a bit-serial modmul.
// RSA_EARLY_EXIT_EN starts the scan at the MSB set bit of d, skipping leading-zero squarings.
module rsa_modexp_decoder #(
  parameter int N   = 10573,
  parameter int N_W = 14,
  parameter int D_W = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           d_valid,
  input  logic [D_W-1:0] d_in,
  input  logic           c_valid,
  output logic           c_ready,
  input  logic [N_W-1:0] c_in,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [N_W-1:0] m_out,
  output logic           busy
);
  localparam int C_W = $clog2(D_W);
  localparam int K_W = $clog2(N_W);
  localparam int A_W = N_W + 2;
  localparam logic [A_W-1:0] N_A = A_W'(N);
  localparam logic [N_W-1:0] N_N = N_W'(N);
  typedef enum logic [2:0] {IDLE, PREP, SQR, MUL, DONE, HOLD} state_t;
  state_t         state_q, state_d;
  logic [D_W-1:0] key_q, key_d, exp_q, exp_d;
  logic           key_ok_q, key_ok_d, m_valid_q, m_valid_d, busy_q, busy_d;
  logic [C_W-1:0] cnt_q, cnt_d, cnt_init;
  logic [K_W-1:0] k_q, k_d;
  logic [A_W-1:0] acc_q, acc_d, sum, s1, s2;
  logic [N_W-1:0] r_q, r_d, base_q, base_d, m_out_q, m_out_d, op_b;
  logic           accept, last;
`ifdef RSA_EARLY_EXIT_EN
  always_comb begin
    cnt_init = '0;
    for (int i = 0; i < D_W; i++) if (key_q[i]) cnt_init = C_W'(i);
  end
`else
  assign cnt_init = C_W'(D_W - 1);
`endif
  assign c_ready = (state_q == IDLE) && key_ok_q && !m_valid_q;
  assign accept  = c_valid && c_ready;
  assign m_valid = m_valid_q;
  assign m_out   = m_out_q;
  assign busy    = busy_q;
  // acc < N on entry, so 2*acc + a < 3N: two conditional subtracts restore acc < N
  assign op_b = (state_q == MUL) ? base_q : r_q;
  assign sum  = {acc_q[A_W-2:0], 1'b0} + (op_b[k_q] ? A_W'(r_q) : '0);
  assign s1   = (sum >= N_A) ? sum - N_A : sum;
  assign s2   = (s1 >= N_A) ? s1 - N_A : s1;
  assign last = (k_q == '0);
  always_comb begin
    state_d   = state_q;
    key_d     = d_valid ? d_in : key_q;
    key_ok_d  = key_ok_q | d_valid;
    exp_d     = exp_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    acc_d     = acc_q;
    r_d       = r_q;
    base_d    = base_q;
    m_out_d   = m_out_q;
    m_valid_d = m_valid_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = PREP;
        base_d  = (c_in >= N_N) ? c_in - N_N : c_in;
        r_d     = N_W'(1);
        exp_d   = key_q;
        cnt_d   = cnt_init;
        busy_d  = 1'b1;
      end
      PREP: begin
        acc_d = '0;
        k_d   = K_W'(N_W - 1);
`ifdef RSA_EARLY_EXIT_EN
        state_d = (exp_q == '0) ? DONE : SQR;
`else
        state_d = SQR;
`endif
      end
      SQR, MUL: begin
        acc_d = s2;
        k_d   = k_q - 1'b1;
        if (last) begin
          r_d   = s2[N_W-1:0];
          acc_d = '0;
          k_d   = K_W'(N_W - 1);
          if (state_q == SQR && exp_q[cnt_q]) state_d = MUL;
          else if (cnt_q == '0) state_d = DONE;
          else begin
            cnt_d   = cnt_q - 1'b1;
            state_d = SQR;
          end
        end
      end
      DONE: begin
        m_out_d   = r_q;
        m_valid_d = 1'b1;
        busy_d    = 1'b0;
        state_d   = HOLD;
      end
      HOLD: if (m_ready) begin
        m_valid_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      key_q     <= '0;
      key_ok_q  <= 1'b0;
      exp_q     <= '0;
      cnt_q     <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      r_q       <= '0;
      base_q    <= '0;
      m_out_q   <= '0;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      key_ok_q  <= key_ok_d;
      exp_q     <= exp_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      r_q       <= r_d;
      base_q    <= base_d;
      m_out_q   <= m_out_d;
      m_valid_q <= m_valid_d;
      busy_q    <= busy_d;
    end
  end
endmodule

// File: tb/tb_rsa_modexp_decoder.sv
// tb_rsa_modexp_decoder: scoreboard bench for rsa_modexp_decoder (value, latency, handshake, reset).
module tb_rsa_modexp_decoder;
  localparam int N = 10573, N_W = 14, D_W = 12;
  logic clk = 1'b0, rst = 1'b1, d_valid = 1'b0, c_valid = 1'b0, m_ready = 1'b1;
  logic [D_W-1:0] d_in = '0;
  logic [N_W-1:0] c_in = '0;
  logic c_ready, m_valid, busy;
  logic [N_W-1:0] m_out;
  rsa_modexp_decoder #(.N(N), .N_W(N_W), .D_W(D_W)) dut (
    .clk(clk), .rst(rst), .d_valid(d_valid), .d_in(d_in), .c_valid(c_valid),
    .c_ready(c_ready), .c_in(c_in), .m_valid(m_valid), .m_ready(m_ready),
    .m_out(m_out), .busy(busy)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int m; int lat;} exp_t;
  exp_t sb[$];
  int n_tests = 0, n_fail = 0, key = 0, acc_cyc = 0, last_m = 0, last_lat = 0;
  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int model_m(input int c, input int d);
    longint r = 1, b = c % N;
    for (int i = 0; i < d; i++) r = (r * b) % N;
    return int'(r);
  endfunction
  function automatic int model_lat(input int d);
    int bl = 0;
    for (int i = 0; i < D_W; i++) if (d[i]) bl = i + 1;
`ifdef RSA_EARLY_EXIT_EN
    return 2 + N_W * (bl + $countones(d));
`else
    return 2 + N_W * (D_W + $countones(d));
`endif
  endfunction
  task automatic load_key(input int d);
    @(negedge clk);
    d_valid = 1'b1;
    d_in = d[D_W-1:0];
    @(negedge clk);
    d_valid = 1'b0;
    key = d;
  endtask
  task automatic start_word(input int c, input bit keep);
    @(negedge clk);
    c_valid = 1'b1;
    c_in = c[N_W-1:0];
    for (int t = 0; !c_ready && t < 2000; t++) @(negedge clk);
    if (!c_ready) begin
      chk("c_ready_timeout", 0, 1);
      c_valid = 1'b0;
      return;
    end
    sb.push_back('{model_m(c, key), model_lat(key)});
    acc_cyc = cyc + 1;
    @(negedge clk);
    if (!keep) c_valid = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
  endtask
  task automatic wait_result();
    int t = 0, bad = 0;
    exp_t e;
    while (!m_valid && t < 5000) begin
      if (c_valid && c_ready) bad++;
      @(negedge clk);
      t++;
    end
    c_valid = 1'b0;
    if (!m_valid || sb.size() == 0) begin
      chk("m_valid_timeout", int'(m_valid), 1);
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    last_m = int'(m_out);
    last_lat = cyc - acc_cyc;
    chk("m_out", last_m, e.m);
    chk("latency", last_lat, e.lat);
    chk("busy_at_valid", int'(busy), 0);
    chk("no_accept_while_busy", bad, 0);
  endtask
  initial begin
    int held;
    repeat (3) @(negedge clk);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_out", int'(m_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_c_ready", int'(c_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("c_ready_no_key", int'(c_ready), 0);
    load_key(233);
    start_word(1, 0);
    wait_result();
    chk("tp_m_c1", last_m, 1);
`ifdef RSA_EARLY_EXIT_EN
    chk("tp_lat_233", last_lat, 184);
`else
    chk("tp_lat_233", last_lat, 240);
`endif
    start_word(10572, 0);
    wait_result();
    chk("tp_m_minus1", last_m, 10572);
    start_word(10574, 0);
    wait_result();
    chk("tp_m_ge_n", last_m, 1);
    load_key(2);
    start_word(100, 0);
    wait_result();
    chk("tp_m_100sq", last_m, 10000);
    start_word(200, 1);
    c_in = 14'd5;
    wait_result();
    chk("tp_m_200sq", last_m, 8281);
`ifdef RSA_EARLY_EXIT_EN
    chk("tp_lat_d2", last_lat, 44);
`else
    chk("tp_lat_d2", last_lat, 184);
`endif
    load_key(1);
    m_ready = 1'b0;
    start_word(1234, 0);
    wait_result();
    held = 0;
    repeat (50) begin
      @(negedge clk);
      if (m_valid && m_out == 14'd1234 && !c_ready) held++;
    end
    chk("hold_stable", held, 50);
    m_ready = 1'b1;
    @(negedge clk);
    chk("hold_release_valid", int'(m_valid), 0);
    chk("release_c_ready", int'(c_ready), 1);
    start_word(50, 0);
    load_key(2);
    wait_result();
    chk("tp_reload_inflight", last_m, 50);
    start_word(50, 0);
    wait_result();
    chk("tp_reload_next", last_m, 2500);
    @(negedge clk);
    for (int t = 0; !c_ready && t < 50; t++) @(negedge clk);
    chk("same_cycle_ready", int'(c_ready), 1);
    c_valid = 1'b1;
    c_in = 14'd3;
    d_valid = 1'b1;
    d_in = 12'd3;
    sb.push_back('{model_m(3, key), model_lat(key)});
    acc_cyc = cyc + 1;
    @(negedge clk);
    c_valid = 1'b0;
    d_valid = 1'b0;
    key = 3;
    wait_result();
    chk("same_cycle_old_key", last_m, 9);
    start_word(3, 0);
    wait_result();
    chk("same_cycle_new_key", last_m, 27);
    start_word(10573, 0);
    wait_result();
    chk("c_zero", last_m, 0);
    start_word(77, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_front());
    chk("midop_rst_m_valid", int'(m_valid), 0);
    chk("midop_rst_busy", int'(busy), 0);
    chk("midop_rst_c_ready", int'(c_ready), 0);
    c_valid = 1'b1;
    c_in = 14'd77;
    repeat (3) @(negedge clk);
    chk("key_cleared_c_ready", int'(c_ready), 0);
    c_valid = 1'b0;
    load_key(0);
    start_word(77, 0);
    wait_result();
    chk("d_zero", last_m, 1);
`ifdef RSA_EARLY_EXIT_EN
    chk("d_zero_lat", last_lat, 2);
`else
    chk("d_zero_lat", last_lat, 170);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
